vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters.
  - Display scan-out reader: fed by the 800x600 pixel iterator.
  - Drawing-engine writer.
- Display reads have priority. The writer gets a bounded-starvation guarantee.
- Memory is double-buffered in two banks. Display and writer banks swap only at end of frame, so frames never tear.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vram_bank_ctrl.sv | 50 +++++
 rtl/vram_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: geometry, widths,
// bank encodings and the arbiter grant-source type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 12;

  localparam logic BANK_0 = 1'b0;
  localparam logic BANK_1 = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DISP,
    SRC_WR,
    SRC_WR_FORCED
  } grant_src_e;

endpackage

// File: rtl/vram_bank_ctrl.sv
// Double-buffer bank control: latches swap requests
// and flips the display bank only at end of frame.
module vram_bank_ctrl
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic swap_req,
  input  logic frame_end,
  output logic disp_bank,
  output logic swap_done
);

  logic pend_q, pend_d;
  logic bank_q, bank_d;
  logic done_q, done_d;
  logic do_swap;

  assign do_swap = frame_end & (pend_q | swap_req);

  // Next state: swap on frame end, else latch a request
  always_comb begin
    pend_d = pend_q;
    bank_d = bank_q;
    done_d = do_swap;
    if (do_swap) begin
      pend_d = 1'b0;
      bank_d = ~bank_q;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  // Bank state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      bank_q <= BANK_0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      bank_q <= bank_d;
      done_q <= done_d;
    end
  end

  assign disp_bank = bank_q;
  assign swap_done = done_q;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display reads first, writer gets a
// forced slot after STARVE_LIMIT denied cycles.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blank,
  input  logic          frame_end,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          disp_bank,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  grant_src_e    src;
  logic          wr_elig;
  logic          forced;
  logic [7:0]    starve_q, starve_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    rd_q;
  logic          bank;

  vram_bank_ctrl u_bank (
    .clk       (clk),
    .rst       (rst),
    .swap_req  (swap_req),
    .frame_end (frame_end),
    .disp_bank (bank),
    .swap_done (swap_done)
  );

  assign wr_elig = !WR_BLANK_ONLY || blank;
  assign forced  = wr_valid && !WR_BLANK_ONLY
                && (starve_q == LIMIT);

  // Priority grant; nothing is granted while in reset
  always_comb begin
    src = SRC_NONE;
    if (rst) begin
      if (forced)
        src = SRC_WR_FORCED;
      else if (disp_req)
        src = SRC_DISP;
      else if (wr_valid && wr_elig)
        src = SRC_WR;
    end
  end

  assign disp_gnt = (src == SRC_DISP);
  assign wr_ready = (src == SRC_WR)
                 || (src == SRC_WR_FORCED);

  // Starvation counter: counts only denied eligible writes
  always_comb begin
    starve_d = '0;
    if (wr_valid && !WR_BLANK_ONLY
        && src == SRC_DISP) begin
      if (starve_q >= LIMIT)
        starve_d = LIMIT;
      else
        starve_d = starve_q + 8'd1;
    end
  end

  // Next memory command built from this cycle's grant
  always_comb begin
    en_d    = (src != SRC_NONE);
    we_d    = wr_ready;
    addr_d  = {bank, disp_addr};
    wdata_d = '0;
    if (wr_ready) begin
      addr_d  = {~bank, wr_addr};
      wdata_d = wr_data;
    end
  end

  // Registered command, counter and read-valid pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= {rd_q[0], disp_gnt};
    end
  end

  assign mem_en      = en_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign disp_rvalid = rd_q[1];
  assign disp_rdata  = rd_q[1] ? mem_rdata : '0;
  assign disp_bank   = bank;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: write, read latency,
// starvation, blank-only writer, bank swap, reset.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        blank, frame_end;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        wr_valid;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        swap_req;
  logic [11:0] mem_rdata;

  logic        disp_gnt, disp_rvalid, wr_ready;
  logic [11:0] disp_rdata, mem_wdata;
  logic        swap_done, disp_bank;
  logic        mem_en, mem_we;
  logic [19:0] mem_addr;

  logic        b_disp_gnt, b_disp_rvalid, b_wr_ready;
  logic [11:0] b_disp_rdata, b_mem_wdata;
  logic        b_swap_done, b_disp_bank;
  logic        b_mem_en, b_mem_we;
  logic [19:0] b_mem_addr;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .blank(blank),
    .frame_end(frame_end), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .swap_req(swap_req),
    .swap_done(swap_done), .disp_bank(disp_bank),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  vram_arbiter #(.WR_BLANK_ONLY(1'b1)) dut_bo (
    .clk(clk), .rst(rst), .blank(blank),
    .frame_end(frame_end), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_gnt(b_disp_gnt),
    .disp_rvalid(b_disp_rvalid),
    .disp_rdata(b_disp_rdata), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(b_wr_ready), .swap_req(swap_req),
    .swap_done(b_swap_done), .disp_bank(b_disp_bank),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    blank = 1'b0; frame_end = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; mem_rdata = '0;

    // reset state
    #2;
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rvalid", disp_rvalid, 0);
    chk("rst_bank", disp_bank, 0);
    chk("rst_swapdone", swap_done, 0);
    wr_valid = 1'b1;
    #1;
    chk("rst_wrready_gated", wr_ready, 0);

    // first write after release goes to bank 1
    #5;
    rst = 1'b1;
    wr_addr = 19'h123; wr_data = 12'h5A5;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_no_dgnt", disp_gnt, 0);
    step();
    wr_valid = 1'b0;
    #1;
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 20'h80123);
    chk("wr_mem_wdata", mem_wdata, 12'h5A5);
    chk("wr_ready_idle", wr_ready, 0);

    // single read, 2-cycle latency from bank 0
    disp_req = 1'b1; disp_addr = 19'd5;
    #1;
    chk("rd_gnt", disp_gnt, 1);
    step();
    disp_req = 1'b0;
    #1;
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 20'h00005);
    chk("rd_rvalid_t1", disp_rvalid, 0);
    step();
    mem_rdata = 12'hABC;
    #1;
    chk("rd_rvalid_t2", disp_rvalid, 1);
    chk("rd_rdata", disp_rdata, 12'hABC);
    chk("rd_idle_en", mem_en, 0);
    step();
    chk("rd_rvalid_t3", disp_rvalid, 0);

    // starvation: 8 display grants, then forced write
    disp_req = 1'b1; wr_valid = 1'b1;
    disp_addr = 19'd40; wr_addr = 19'd77;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk($sformatf("starve_dgnt_%0d", k),
          disp_gnt, (k % 9 != 8));
      chk($sformatf("starve_wrdy_%0d", k),
          wr_ready, (k % 9 == 8));
      if (k >= 1)
        chk($sformatf("starve_we_%0d", k),
            mem_we, ((k - 1) % 9 == 8));
      step();
    end
    disp_req = 1'b0; wr_valid = 1'b0;
    step();

    // blank-only writer waits for blank
    wr_valid = 1'b1; blank = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("bo_wait_%0d", k),
          b_wr_ready, 0);
      step();
    end
    blank = 1'b1;
    #1;
    chk("bo_blank_rdy", b_wr_ready, 1);
    chk("bo_blank_dgnt", b_disp_gnt, 0);
    step();
    chk("bo_mem_we", b_mem_we, 1);
    wr_valid = 1'b0; blank = 1'b0;
    step();

    // bank swap at frame end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("swap_pre_bank", disp_bank, 0);
    frame_end = 1'b1;
    wr_valid = 1'b1; wr_addr = 19'd7;
    step();
    frame_end = 1'b0;
    wr_addr = 19'd8;
    #1;
    chk("swap_bank", disp_bank, 1);
    chk("swap_done", swap_done, 1);
    chk("swap_preswap_wr", mem_addr, 20'h80007);
    step();
    wr_valid = 1'b0;
    #1;
    chk("swap_done_pulse", swap_done, 0);
    chk("swap_post_wr", mem_addr, 20'h00008);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    #1;
    chk("nopend_bank", disp_bank, 1);
    chk("nopend_done", swap_done, 0);

    // reset mid-read drops the in-flight read
    disp_req = 1'b1; disp_addr = 19'd9;
    step();
    disp_req = 1'b0;
    #1;
    chk("mid_rd_en", mem_en, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_bank", disp_bank, 0);
    chk("mid_rst_rvalid", disp_rvalid, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    step();
    chk("post_rst_rvalid1", disp_rvalid, 0);
    chk("post_rst_rdata", disp_rdata, 0);
    step();
    chk("post_rst_rvalid2", disp_rvalid, 0);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
